// File: rtl/muldiv_unit_with_lock.sv
// Shared multiply/divide unit that one requester at a time owns through a lock handshake.
// The oldest issue ID wins a free unit; ownership is held until that port drops lock_req.
module muldiv_unit_with_lock #(
    parameter int NUM_PORTS   = 2,
    parameter int ID_WIDTH    = 16,
    parameter int MUL_LATENCY = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0]                 lock_req,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]   lock_id,
    input  logic [NUM_PORTS-1:0]                 op_valid,
    input  logic [NUM_PORTS-1:0][1:0]            op,
    input  logic [NUM_PORTS-1:0][31:0]           src_a,
    input  logic [NUM_PORTS-1:0][31:0]           src_b,
    output logic [NUM_PORTS-1:0]                 grant,
    output logic                                 busy,
    output logic [NUM_PORTS-1:0]                 done,
    output logic [31:0]                          hi,
    output logic [31:0]                          lo
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_OWNED, S_MUL, S_DIV, S_DONE} state_t;

    state_t                 state_reg, state_next;
    logic [NUM_PORTS-1:0]   grant_reg;
    logic [IDX_W-1:0]       owner_reg;
    logic [31:0]            a_reg, b_reg, rem_reg, quo_reg, hi_reg, lo_reg;
    logic [1:0]             op_reg;
    logic [4:0]             cnt_reg;

    logic                   arb_found;
    logic [IDX_W-1:0]       arb_idx;
    logic [ID_WIDTH-1:0]    arb_id;
    logic                   owner_req, accept, load_result;
    logic [31:0]            cur_a, cur_b, abs_a, divisor_mag, rem_next, quo_next, q_fix, r_fix;
    logic [1:0]             cur_op;
    logic [63:0]            ext_a, ext_b, product, result;
    logic [33:0]            trial;

    // Modular age compare keeps working when issue IDs wrap around.
    function automatic logic is_older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b);
        logic [ID_WIDTH-1:0] d;
        d = a - b;
        return d[ID_WIDTH-1];
    endfunction

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_id    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (lock_req[i] && (!arb_found || is_older(lock_id[i], arb_id))) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(i);
                arb_id    = lock_id[i];
            end
        end
    end

    assign owner_req = lock_req[owner_reg];

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            S_IDLE:  if (arb_found) state_next = S_OWNED;
            S_OWNED: begin
                if (!owner_req) begin
                    state_next = S_IDLE;
                end else if (op_valid[owner_reg]) begin
                    accept = 1'b1;
                    if (op[owner_reg][1])      state_next = S_DIV;
                    else if (MUL_LATENCY == 1) state_next = S_DONE;
                    else                       state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (!owner_req)                            state_next = S_IDLE;
                else if (cnt_reg == 5'(MUL_LATENCY - 1))   state_next = S_DONE;
            end
            S_DIV: begin
                if (!owner_req)             state_next = S_IDLE;
                else if (cnt_reg == 5'd31)  state_next = S_DONE;
            end
            S_DONE:  state_next = owner_req ? S_OWNED : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign load_result = (state_next == S_DONE) && (state_reg != S_DONE);

    // A single-cycle multiply finishes on the accept edge, so it reads the live operands.
    always_comb begin
        cur_a  = (state_reg == S_OWNED) ? src_a[owner_reg] : a_reg;
        cur_b  = (state_reg == S_OWNED) ? src_b[owner_reg] : b_reg;
        cur_op = (state_reg == S_OWNED) ? op[owner_reg]    : op_reg;
        ext_a  = {(cur_op[0] ? 32'd0 : {32{cur_a[31]}}), cur_a};
        ext_b  = {(cur_op[0] ? 32'd0 : {32{cur_b[31]}}), cur_b};
        product = ext_a * ext_b;
        abs_a  = (cur_op == 2'd2 && cur_a[31]) ? (32'd0 - cur_a) : cur_a;
    end

    // One restoring step; the final step's output feeds the result directly.
    always_comb begin
        divisor_mag = (op_reg == 2'd2 && b_reg[31]) ? (32'd0 - b_reg) : b_reg;
        trial       = {1'b0, rem_reg, quo_reg[31]} - {2'b00, divisor_mag};
        if (!trial[33]) begin
            rem_next = trial[31:0];
            quo_next = {quo_reg[30:0], 1'b1};
        end else begin
            rem_next = {rem_reg[30:0], quo_reg[31]};
            quo_next = {quo_reg[30:0], 1'b0};
        end
        q_fix = (op_reg == 2'd2 && (a_reg[31] ^ b_reg[31])) ? (32'd0 - quo_next) : quo_next;
        r_fix = (op_reg == 2'd2 && a_reg[31]) ? (32'd0 - rem_next) : rem_next;
        if (state_reg != S_DIV)  result = product;
        else if (b_reg == 32'd0) result = {a_reg, 32'hFFFF_FFFF};
        else                     result = {r_fix, q_fix};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            grant_reg <= '0;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && arb_found) begin
                grant_reg          <= '0;
                grant_reg[arb_idx] <= 1'b1;
                owner_reg          <= arb_idx;
            end else if (state_next == S_IDLE) begin
                grant_reg <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            rem_reg <= '0;
            quo_reg <= '0;
            cnt_reg <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
        end else begin
            if (accept) begin
                a_reg   <= cur_a;
                b_reg   <= cur_b;
                op_reg  <= cur_op;
                rem_reg <= '0;
                quo_reg <= abs_a;
                cnt_reg <= cur_op[1] ? 5'd0 : 5'd1;
            end else if (state_reg == S_MUL) begin
                cnt_reg <= cnt_reg + 5'd1;
            end else if (state_reg == S_DIV) begin
                cnt_reg <= cnt_reg + 5'd1;
                rem_reg <= rem_next;
                quo_reg <= quo_next;
            end
            if (load_result) begin
                hi_reg <= result[63:32];
                lo_reg <= result[31:0];
            end
        end
    end

    assign grant = grant_reg;
    assign busy  = (state_reg == S_MUL) || (state_reg == S_DIV);
    assign done  = (state_reg == S_DONE) ? grant_reg : '0;
    assign hi    = hi_reg;
    assign lo    = lo_reg;
endmodule

// File: tb/tb_muldiv_unit_with_lock.sv
// Randomized and directed bench for muldiv_unit_with_lock against an arithmetic reference model.
module tb_muldiv_unit_with_lock;
    localparam int NP  = 2;
    localparam int IDW = 16;
    localparam int ML  = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NP-1:0]            lock_req, op_valid, grant, done;
    logic [NP-1:0][IDW-1:0]   lock_id;
    logic [NP-1:0][1:0]       op;
    logic [NP-1:0][31:0]      src_a, src_b;
    logic                     busy;
    logic [31:0]              hi, lo;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit_with_lock #(.NUM_PORTS(NP), .ID_WIDTH(IDW), .MUL_LATENCY(ML)) dut (
        .clk(clk), .rst(rst), .lock_req(lock_req), .lock_id(lock_id),
        .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
        .grant(grant), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'd0: return 64'(sa * sb);
            2'd1: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 2'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    function automatic logic id_older(input logic [IDW-1:0] a, input logic [IDW-1:0] b);
        logic [IDW-1:0] d;
        d = a - b;
        return d[IDW-1];
    endfunction

    task automatic acquire(input int p, input logic [IDW-1:0] id);
        lock_req[p] = 1'b1;
        lock_id[p]  = id;
        tick();
        chk("acquire_grant", 64'(grant), 64'(1 << p));
    endtask

    task automatic release_port(input int p);
        lock_req[p] = 1'b0;
        tick();
        chk("release_grant", 64'(grant), 64'd0);
    endtask

    task automatic run_op(input int p, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int lat, cyc;
        exp = model(o, a, b);
        lat = o[1] ? 33 : ML;
        op_valid[p] = 1'b1;
        op[p] = o;
        src_a[p] = a;
        src_b[p] = b;
        tick();
        // Keep op_valid high with fresh operands: must be ignored while busy.
        src_a[p] = $urandom;
        src_b[p] = $urandom;
        op[p]    = 2'($urandom);
        if (lat > 1) chk("busy_run", 64'(busy), 64'd1);
        cyc = 1;
        while (done == '0 && cyc < 64) begin
            tick();
            op_valid[p] = 1'b0;
            cyc++;
        end
        op_valid[p] = 1'b0;
        $display("txn port=%0d op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", p, o, a, b, hi, lo, cyc);
        chk("latency", 64'(cyc), 64'(lat));
        chk("done_port", 64'(done), 64'(1 << p));
        chk("hi", 64'(hi), 64'(exp[63:32]));
        chk("lo", 64'(lo), 64'(exp[31:0]));
        tick();
        chk("done_clear", 64'(done), 64'd0);
    endtask

    initial begin
        logic [IDW-1:0] id0, id1;
        logic [31:0] a, b, save_hi, save_lo;
        logic [1:0] o;
        int p, ndone;

        rst = 1'b1;
        lock_req = '0; op_valid = '0; lock_id = '0; op = '0; src_a = '0; src_b = '0;
        // Both ports already requesting while reset is held.
        lock_req = 2'b11;
        lock_id[0] = 16'd5;
        lock_id[1] = 16'd3;
        tick(); tick();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        tick();
        chk("age_first", 64'(grant), 64'b10);
        lock_req[1] = 1'b0;
        tick();
        chk("age_gap", 64'(grant), 64'd0);
        tick();
        chk("age_next", 64'(grant), 64'b01);
        release_port(0);

        lock_req = 2'b11;
        lock_id[0] = 16'hFFFE;
        lock_id[1] = 16'h0001;
        tick();
        chk("wrap", 64'(grant), 64'b01);
        lock_req = '0;
        tick();

        for (int i = 0; i < 8; i++) begin
            id0 = 16'($urandom);
            id1 = ($urandom_range(0, 3) == 0) ? id0 : 16'($urandom);
            if (16'(id1 - id0) == 16'h8000) id1 = id1 + 16'd1;
            lock_id[0] = id0;
            lock_id[1] = id1;
            lock_req = 2'b11;
            tick();
            $display("txn arb id0=%h id1=%h grant=%b", id0, id1, grant);
            chk("arb_rand", 64'(grant), id_older(id1, id0) ? 64'b10 : 64'b01);
            lock_req = '0;
            tick();
        end

        acquire(0, 16'd40);
        op_valid[1] = 1'b1;
        op[1] = 2'd0;
        tick();
        op_valid[1] = 1'b0;
        chk("nonowner_busy", 64'(busy), 64'd0);
        run_op(0, 2'd0, 32'hFFFF_FFFE, 32'd3);
        run_op(0, 2'd1, 32'hFFFF_FFFE, 32'd3);
        run_op(0, 2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(0, 2'd3, 32'd100, 32'd0);
        run_op(0, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(0, 2'd2, 32'd7, 32'hFFFF_FFFE);
        release_port(0);

        for (int i = 0; i < 12; i++) begin
            p = int'($urandom_range(0, 1));
            o = 2'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            acquire(p, 16'($urandom));
            run_op(p, o, a, b);
            release_port(p);
        end

        // Abort mid-divide with another port waiting.
        acquire(0, 16'd10);
        save_hi = hi;
        save_lo = lo;
        lock_id[1] = 16'd20;
        lock_req[1] = 1'b1;
        op_valid[0] = 1'b1;
        op[0] = 2'd3;
        src_a[0] = 32'd12345;
        src_b[0] = 32'd7;
        tick();
        op_valid[0] = 1'b0;
        repeat (9) tick();
        lock_req[0] = 1'b0;
        tick();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_grant", 64'(grant), 64'd0);
        tick();
        chk("abort_next", 64'(grant), 64'b10);
        ndone = 0;
        repeat (40) begin
            tick();
            if (done[0]) ndone++;
        end
        $display("txn abort hi=%h lo=%h late_done=%0d", hi, lo, ndone);
        chk("abort_nodone", 64'(ndone), 64'd0);
        chk("abort_hilo", {hi, lo}, {save_hi, save_lo});
        release_port(1);

        // Asynchronous reset in the middle of a divide.
        acquire(0, 16'd77);
        op_valid[0] = 1'b1;
        op[0] = 2'd2;
        src_a[0] = 32'hFFFF_F000;
        src_b[0] = 32'd3;
        tick();
        op_valid[0] = 1'b0;
        repeat (19) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_grant", 64'(grant), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        lock_req = '0;
        tick(); tick();
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            tick();
            if (done != '0) ndone++;
        end
        $display("txn reset_mid_div late_done=%0d", ndone);
        chk("rst_mid_nodone", 64'(ndone), 64'd0);

        acquire(1, 16'd1);
        run_op(1, 2'd0, 32'd1000, 32'hFFFF_FFFF);
        release_port(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit_with_lock.md
MULDIV_UNIT_WITH_LOCK -- requirements
Module: muldiv_unit_with_lock

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of SIC requester ports.
REQ-002 SHALL have parameter ID_WIDTH, default 16, issue-ID width used for age arbitration.
REQ-003 SHALL have parameter MUL_LATENCY, default 3, cycles from accepted multiply to done (legal range 1..8).
REQ-004 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-high.
- lock_req  in  [NUM_PORTS]  port requests exclusive ownership.
- lock_id  in  [NUM_PORTS][ID_WIDTH]  issue ID of requesting instruction.
- op_valid  in  [NUM_PORTS]  one-cycle operation start pulse from owner.
- op  in  [NUM_PORTS][2]  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- src_a, src_b  in  [NUM_PORTS][32]  operands (dividend/divisor for DIV).
- grant  out  [NUM_PORTS]  one-hot ownership.
- busy  out  1  operation in flight.
- done  out  [NUM_PORTS]  one-cycle completion pulse to owner.
- hi, lo  out  32 each  result registers, shared.

Function
REQ-005 SHALL be the responder end of the SIC lock protocol: a port holds lock_req high until finished; the unit grants at most one port at a time.
REQ-006 SHALL arbitrate only when no port is granted: among asserted lock_req, grant the oldest ID; A older than B iff MSB of (A-B) mod 2^ID_WIDTH is 1; equal IDs -> lowest port index.
REQ-007 grant SHALL be registered: asserted the cycle after arbitration, held while owner's lock_req stays high.
REQ-008 SHALL drop grant the cycle after owner deasserts lock_req; arbitration of others may occur in that same release cycle (grant to next port at earliest one cycle after old grant drops).
REQ-009 States: IDLE (no owner), OWNED (owner, no op), MUL, DIV, DONE.
REQ-010 IDLE->OWNED on grant; OWNED->MUL/DIV on owner op_valid; MUL->DONE after MUL_LATENCY cycles counted from op_valid cycle; DIV->DONE after exactly 33 cycles (1 setup + 32 restoring iterations); DONE->OWNED next cycle.
REQ-011 op_valid from non-owner ports SHALL be ignored; owner op_valid while busy SHALL be ignored.
REQ-012 busy SHALL be 1 in MUL and DIV, else 0.
REQ-013 done[owner] SHALL pulse exactly one cycle in DONE; hi/lo update in the same cycle and hold until next DONE.
REQ-014 MULT: {hi,lo} = signed 64-bit product; MULTU: unsigned 64-bit product.
REQ-015 DIVU: lo=quotient, hi=remainder. DIV: quotient truncated toward zero, remainder sign of dividend; magnitudes computed unsigned then corrected.
REQ-016 Divisor zero SHALL give lo=32'hFFFF_FFFF, hi=src_a, same 33-cycle latency.
REQ-017 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL give lo=32'h8000_0000, hi=0.
REQ-018 Operands SHALL be latched on accepted op_valid; later input changes do not affect the result.
REQ-019 Owner lock_req deassert during MUL/DIV SHALL abort (rollback): no done, hi/lo unchanged, state IDLE next cycle with grant dropped.
REQ-020 Owner lock_req deassert in DONE: done still pulses, hi/lo updated, then IDLE.

Reset
REQ-021 On rst: state IDLE, grant=0, busy=0, done=0, hi=0, lo=0, counters 0; asynchronous, effective mid-operation with no done afterward.
REQ-022 First arbitration SHALL occur on the first rising clk edge after rst deasserts.

Verification
REQ-023 Age arbitration: port0 id=5, port1 id=3 same cycle -> grant=2'b10 next cycle; port1 releases -> grant 0 one cycle, then 2'b01.
REQ-024 Wrap-around: port0 id=16'hFFFE, port1 id=16'h0001 -> port0 granted (older).
REQ-025 Multiply: MULT 32'hFFFF_FFFE x 3 -> done after 3 cycles, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA; MULTU same operands -> hi=2, lo=32'hFFFF_FFFA.
REQ-026 Divide: DIV -7/2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF, done at cycle 33; DIVU 100/0 -> lo=32'hFFFF_FFFF, hi=100.
REQ-027 Abort: DIVU started, owner drops lock_req at cycle 10 -> no done ever, hi/lo unchanged, busy=0 next cycle, other pending port granted afterward.
REQ-028 Reset mid-DIV: rst pulse at cycle 20 -> all outputs 0 immediately, no done after release.
